bus_arb_rr: RTL and testbench

//  Two-master round-robin arbiter for the req/ack/resp memory bus; replaces fixed-priority muxing of
//  UDM and CPU data ports onto one bus_unit_memsplit slave port. Grants one master per cycle, tracks

---
 rtl/bus_arb_rr_pkg.sv | 13 +
 rtl/bus_arb_idfifo.sv | 62 ++++++
 rtl/bus_arb_rr.sv | 114 +++++++++++
 tb/tb_bus_arb_rr.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_rr_pkg.sv
// Shared definitions for the two-master round-robin bus arbiter.
package bus_arb_rr_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic {
    MID_UDM = 1'b0,
    MID_CPU = 1'b1
  } mid_e;

endpackage

// File: rtl/bus_arb_idfifo.sv
// In-order FIFO of 1-bit master IDs for outstanding reads; push when full / pop when empty are ignored.
module bus_arb_idfifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     din_i,
  input  logic                     pop_i,
  output logic                     dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push_i & ~full_o;
    pop_ok   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/bus_arb_rr.sv
// Two-master round-robin arbiter onto one req/ack/resp slave port; read responses are
// routed back to the issuing master through an in-order ID FIFO.
module bus_arb_rr
  import bus_arb_rr_pkg::*;
#(
  parameter int unsigned MAX_RD = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_W-1:0]       m0_addr_bi,
  input  logic [BE_W-1:0]         m0_be_bi,
  input  logic [DATA_W-1:0]       m0_wdata_bi,
  output logic                    m0_ack_o,
  output logic                    m0_resp_o,
  output logic [DATA_W-1:0]       m0_rdata_bo,
  input  logic                    m1_req_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_W-1:0]       m1_addr_bi,
  input  logic [BE_W-1:0]         m1_be_bi,
  input  logic [DATA_W-1:0]       m1_wdata_bi,
  output logic                    m1_ack_o,
  output logic                    m1_resp_o,
  output logic [DATA_W-1:0]       m1_rdata_bo,
  output logic                    s_req_o,
  output logic                    s_we_o,
  output logic [ADDR_W-1:0]       s_addr_bo,
  output logic [BE_W-1:0]         s_be_bo,
  output logic [DATA_W-1:0]       s_wdata_bo,
  input  logic                    s_ack_i,
  input  logic                    s_resp_i,
  input  logic [DATA_W-1:0]       s_rdata_bi,
  output logic [$clog2(MAX_RD):0] rd_pend_o,
  output logic                    err_o
);

  mid_e prio_q, prio_d;
  logic err_q,  err_d;
  mid_e gid;
  mid_e head;
  logic elig0, elig1, gnt, accept, push, pop;
  logic fifo_full, fifo_empty, fifo_dout;

  bus_arb_idfifo #(.DEPTH(MAX_RD)) u_idfifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (gid),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (rd_pend_o)
  );

  assign head  = mid_e'(fifo_dout);
  assign err_o = err_q;

  always_comb begin
    // Reads are ineligible while the ID FIFO is full; writes never need a slot.
    elig0 = m0_req_i & (m0_we_i | ~fifo_full);
    elig1 = m1_req_i & (m1_we_i | ~fifo_full);
    gnt   = (elig0 | elig1) & ~rst_i;
    if (elig0 & elig1) gid = prio_q;
    else if (elig1)    gid = MID_CPU;
    else               gid = MID_UDM;

    s_req_o    = gnt;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    if (gnt) begin
      if (gid == MID_CPU) begin
        s_we_o     = m1_we_i;
        s_addr_bo  = m1_addr_bi;
        s_be_bo    = m1_be_bi;
        s_wdata_bo = m1_wdata_bi;
      end else begin
        s_we_o     = m0_we_i;
        s_addr_bo  = m0_addr_bi;
        s_be_bo    = m0_be_bi;
        s_wdata_bo = m0_wdata_bi;
      end
    end

    m0_ack_o = gnt & (gid == MID_UDM) & s_ack_i;
    m1_ack_o = gnt & (gid == MID_CPU) & s_ack_i;
    accept   = gnt & s_ack_i;
    push     = accept & ~s_we_o;

    pop         = s_resp_i & ~fifo_empty & ~rst_i;
    m0_resp_o   = pop & (head == MID_UDM);
    m1_resp_o   = pop & (head == MID_CPU);
    m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
    m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

    prio_d = prio_q;
    if (accept) prio_d = (gid == MID_UDM) ? MID_CPU : MID_UDM;
    err_d = err_q | (s_resp_i & fifo_empty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= MID_UDM;
      err_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_arb_rr.sv
// Directed bench for bus_arb_rr with hand-computed expectations (MAX_RD = 4).
module tb_bus_arb_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m0_resp, m1_ack, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_ack, s_resp;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic [2:0]  rd_pend;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_arb_rr #(.MAX_RD(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr), .m0_be_bi(m0_be),
    .m0_wdata_bi(m0_wdata), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_bo(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr), .m1_be_bi(m1_be),
    .m1_wdata_bi(m1_wdata), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_bo(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be), .s_wdata_bo(s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
    .rd_pend_o(rd_pend), .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 32'h1000; m0_be = 4'hF; m0_wdata = 32'hA0;
    m1_req = 0; m1_we = 0; m1_addr = 32'h2000; m1_be = 4'h3; m1_wdata = 32'hB0;
    s_ack = 0; s_resp = 0; s_rdata = '0;
    tick();

    // outputs gated while in reset
    m0_req = 1; m0_we = 1; s_ack = 1; s_resp = 1;
    #1;
    chk("rst_sreq", 32'(s_req), 0);
    chk("rst_m0ack", 32'(m0_ack), 0);
    chk("rst_m0resp", 32'(m0_resp), 0);
    tick();
    chk("rst_pend", 32'(rd_pend), 0);
    chk("rst_err", 32'(err), 0);
    rst = 0; m0_req = 0; s_resp = 0; s_ack = 0;
    #1;
    chk("idle_sreq", 32'(s_req), 0);
    chk("idle_saddr", s_addr, 0);

    // continuous writes from both masters alternate starting with m0
    m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1; s_ack = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_m0ack", 32'(m0_ack), (i % 2 == 0) ? 1 : 0);
      chk("alt_m1ack", 32'(m1_ack), (i % 2 == 0) ? 0 : 1);
      chk("alt_saddr", s_addr, (i % 2 == 0) ? 32'h1000 : 32'h2000);
      chk("alt_sbe", 32'(s_be), (i % 2 == 0) ? 32'hF : 32'h3);
      tick();
    end
    m0_req = 0; m1_req = 0;

    // single m1 read, response two cycles after ack
    m1_req = 1; m1_we = 0; m1_addr = 32'h100;
    #1;
    chk("rd1_m1ack", 32'(m1_ack), 1);
    chk("rd1_swe", 32'(s_we), 0);
    chk("rd1_saddr", s_addr, 32'h100);
    tick();
    m1_req = 0;
    #1;
    chk("rd1_pend1", 32'(rd_pend), 1);
    tick();
    s_resp = 1; s_rdata = 32'hCAFEF00D;
    #1;
    chk("rd1_m1resp", 32'(m1_resp), 1);
    chk("rd1_m1rdata", m1_rdata, 32'hCAFEF00D);
    chk("rd1_m0resp", 32'(m0_resp), 0);
    chk("rd1_m0rdata", m0_rdata, 0);
    tick();
    s_resp = 0;
    #1;
    chk("rd1_pend0", 32'(rd_pend), 0);

    // back-to-back reads m0 then m1, in-order responses
    m0_req = 1; m0_we = 0; m1_req = 1; m1_we = 0;
    #1;
    chk("b2b_m0ack", 32'(m0_ack), 1);
    chk("b2b_m1ack0", 32'(m1_ack), 0);
    tick();
    m0_req = 0;
    #1;
    chk("b2b_m1ack", 32'(m1_ack), 1);
    tick();
    m1_req = 0;
    #1;
    chk("b2b_pend2", 32'(rd_pend), 2);
    s_resp = 1; s_rdata = 32'h11111111;
    #1;
    chk("b2b_r1_m0resp", 32'(m0_resp), 1);
    chk("b2b_r1_m0rdata", m0_rdata, 32'h11111111);
    chk("b2b_r1_m1resp", 32'(m1_resp), 0);
    tick();
    s_rdata = 32'h22222222;
    #1;
    chk("b2b_r2_m1resp", 32'(m1_resp), 1);
    chk("b2b_r2_m1rdata", m1_rdata, 32'h22222222);
    chk("b2b_r2_m0resp", 32'(m0_resp), 0);
    tick();
    s_resp = 0;
    #1;
    chk("b2b_pend0", 32'(rd_pend), 0);

    // fill the ID FIFO with four m1 reads
    m1_req = 1; m1_we = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_m1ack", 32'(m1_ack), 1);
      tick();
    end
    m1_we = 1; m1_addr = 32'h300; m0_req = 1; m0_we = 0; m0_addr = 32'h400;
    #1;
    chk("full_pend", 32'(rd_pend), 4);
    chk("full_m0ack", 32'(m0_ack), 0);
    chk("full_m1wack", 32'(m1_ack), 1);
    chk("full_swe", 32'(s_we), 1);
    tick();
    m1_req = 0;
    #1;
    chk("full_sreq", 32'(s_req), 0);
    chk("full_m0ack2", 32'(m0_ack), 0);
    s_resp = 1; s_rdata = 32'h33;
    #1;
    chk("full_pop_m1resp", 32'(m1_resp), 1);
    chk("full_pop_m0ack", 32'(m0_ack), 0);
    tick();
    s_resp = 0;
    #1;
    chk("freed_pend", 32'(rd_pend), 3);
    chk("freed_m0ack", 32'(m0_ack), 1);
    chk("freed_saddr", s_addr, 32'h400);
    tick();
    m0_req = 0;
    #1;
    chk("refill_pend", 32'(rd_pend), 4);

    // drain two m1 entries, leaving {m1, m0}
    s_resp = 1; s_rdata = 32'h44;
    #1;
    chk("drain1_m1resp", 32'(m1_resp), 1);
    tick();
    #1;
    chk("drain2_m1resp", 32'(m1_resp), 1);
    tick();
    s_resp = 0;
    #1;
    chk("drain_pend2", 32'(rd_pend), 2);

    // simultaneous push and pop at occupancy 2
    m1_req = 1; m1_we = 0; m1_addr = 32'h500; s_resp = 1; s_rdata = 32'h55;
    #1;
    chk("pp_m1ack", 32'(m1_ack), 1);
    chk("pp_m1resp", 32'(m1_resp), 1);
    chk("pp_m1rdata", m1_rdata, 32'h55);
    chk("pp_m0resp", 32'(m0_resp), 0);
    tick();
    m1_req = 0; s_resp = 0;
    #1;
    chk("pp_pend2", 32'(rd_pend), 2);
    s_resp = 1; s_rdata = 32'h66;
    #1;
    chk("pp_r1_m0resp", 32'(m0_resp), 1);
    chk("pp_r1_m0rdata", m0_rdata, 32'h66);
    chk("pp_r1_m1rdata", m1_rdata, 0);
    tick();
    s_rdata = 32'h77;
    #1;
    chk("pp_r2_m1resp", 32'(m1_resp), 1);
    chk("pp_r2_m1rdata", m1_rdata, 32'h77);
    tick();
    s_resp = 0;
    #1;
    chk("pp_pend0", 32'(rd_pend), 0);

    // response with nothing outstanding sets sticky err
    s_resp = 1; s_rdata = 32'h88;
    #1;
    chk("orph_m0resp", 32'(m0_resp), 0);
    chk("orph_m1resp", 32'(m1_resp), 0);
    chk("orph_err_pre", 32'(err), 0);
    tick();
    s_resp = 0;
    #1;
    chk("orph_err", 32'(err), 1);
    tick();
    chk("orph_err_held", 32'(err), 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("orph_err_clr", 32'(err), 0);

    // reset mid-transaction discards the pending ID; stale resp flags err
    m0_req = 1; m0_we = 0;
    #1;
    chk("stale_m0ack", 32'(m0_ack), 1);
    tick();
    m0_req = 0;
    #1;
    chk("stale_pend1", 32'(rd_pend), 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("stale_pend0", 32'(rd_pend), 0);
    s_resp = 1;
    #1;
    chk("stale_m0resp", 32'(m0_resp), 0);
    tick();
    s_resp = 0;
    #1;
    chk("stale_err", 32'(err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
